// File: rtl/display_pkg.sv
// Shared types and constants for the display binary-to-BCD converter.
package display_pkg;

    localparam int unsigned BIN_W   = 20;
    localparam int unsigned DIGITS  = 6;
    localparam int unsigned BCD_W   = 4 * DIGITS;
    localparam int unsigned LED_W   = 5;
    localparam int unsigned CNT_W   = 5;
    localparam int unsigned BCD_MAX = 999999;

    localparam logic [BCD_W-1:0] BCD_ERR   = 24'hEEEEEE;
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(BIN_W - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    // True when the value cannot be shown in DIGITS decimal digits.
    function automatic logic is_ovf(input logic [BIN_W-1:0] bin);
        return bin > BIN_W'(BCD_MAX);
    endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// Double-dabble nibble correction: add 3 when the digit is 5 or more.
module bcd_digit_adj (
    input  logic [3:0] digit_i,
    output logic [3:0] digit_c
);

    always_comb begin
        digit_c = digit_i;
        if (digit_i >= 4'd5) begin
            digit_c = digit_i + 4'd3;
        end
    end

endmodule

// File: rtl/display_bcd_converter.sv
// Iterative 20-bit binary to 6-digit BCD converter, one double-dabble step per clock,
// feeding the seven-segment decoder with digits and LED field updated on the same edge.
module display_bcd_converter
    import display_pkg::*;
#(
    parameter int unsigned BIN_W  = 20,
    parameter int unsigned DIGITS = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [BIN_W-1:0]      bin_in,
    input  logic [LED_W-1:0]      leds_in,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic [LED_W-1:0]      leds_out,
    output logic                  busy,
    output logic                  done,
    output logic                  ovf
);

    localparam int unsigned ACC_W = 4 * DIGITS;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [BIN_W-1:0]   bin_q, bin_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [LED_W-1:0]   leds_cap_q, leds_cap_d;
    logic               ovf_pend_q, ovf_pend_d;
    logic [ACC_W-1:0]   bcd_out_q, bcd_out_d;
    logic [LED_W-1:0]   leds_out_q, leds_out_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               ovf_q, ovf_d;
    logic [ACC_W-1:0]   acc_adj;

    // Per-digit add-3 correction applied ahead of every shift.
    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_digit_adj u_adj (
            .digit_i (acc_q[4*g +: 4]),
            .digit_c (acc_adj[4*g +: 4])
        );
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bin_d      = bin_q;
        acc_d      = acc_q;
        leds_cap_d = leds_cap_q;
        ovf_pend_d = ovf_pend_q;
        bcd_out_d  = bcd_out_q;
        leds_out_d = leds_out_q;
        ovf_d      = ovf_q;
        done_d     = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (load) begin
                    state_d    = SHIFT;
                    bin_d      = bin_in;
                    acc_d      = '0;
                    leds_cap_d = leds_in;
                    ovf_pend_d = is_ovf(BIN_W'(bin_in));
                    cnt_d      = '0;
                end
            end
            SHIFT: begin
                acc_d = {acc_adj[ACC_W-2:0], bin_q[BIN_W-1]};
                bin_d = {bin_q[BIN_W-2:0], 1'b0};
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_STEP) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                // Out-of-range inputs still shift through; the digits are replaced here.
                bcd_out_d  = ovf_pend_q ? ACC_W'(BCD_ERR) : acc_q;
                leds_out_d = leds_cap_q;
                ovf_d      = ovf_pend_q;
                done_d     = 1'b1;
                state_d    = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            bin_q      <= '0;
            acc_q      <= '0;
            leds_cap_q <= '0;
            ovf_pend_q <= 1'b0;
            bcd_out_q  <= '0;
            leds_out_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bin_q      <= bin_d;
            acc_q      <= acc_d;
            leds_cap_q <= leds_cap_d;
            ovf_pend_q <= ovf_pend_d;
            bcd_out_q  <= bcd_out_d;
            leds_out_q <= leds_out_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            ovf_q      <= ovf_d;
        end
    end

    assign bcd_out  = bcd_out_q;
    assign leds_out = leds_out_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign ovf      = ovf_q;

endmodule

// File: tb/tb_display_bcd_converter.sv
// Self-checking bench for display_bcd_converter: vector table, corner sequences, random values.
module tb_display_bcd_converter;

    logic        clk = 1'b0;
    logic        rst;
    logic        load;
    logic [19:0] bin_in;
    logic [4:0]  leds_in;
    logic [23:0] bcd_out;
    logic [4:0]  leds_out;
    logic        busy;
    logic        done;
    logic        ovf;

    int n_cmp  = 0;
    int n_fail = 0;

    display_bcd_converter dut (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .bin_in   (bin_in),
        .leds_in  (leds_in),
        .bcd_out  (bcd_out),
        .leds_out (leds_out),
        .busy     (busy),
        .done     (done),
        .ovf      (ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [19:0] b;
        logic [4:0]  l;
        logic [23:0] eb;
        logic [4:0]  el;
        logic        eo;
    } vec_t;

    vec_t tbl[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Decimal digits by repeated division; out-of-range shows as all E.
    function automatic logic [23:0] ref_bcd(input int unsigned v);
        logic [23:0] r;
        int unsigned x;
        if (v > 999999) return 24'hEEEEEE;
        r = '0;
        x = v;
        for (int i = 0; i < 6; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    // Start a conversion from just after an edge and return in the done cycle.
    task automatic do_conv(input logic [19:0] b, input logic [4:0] l, input int inj_at,
                           output int lat, output int busy_cnt, output bit stable);
        logic [23:0] pb;
        logic [4:0]  pl;
        logic        po;
        pb = bcd_out;
        pl = leds_out;
        po = ovf;
        load    = 1'b1;
        bin_in  = b;
        leds_in = l;
        @(posedge clk); #1;
        load    = 1'b0;
        bin_in  = 20'($urandom);
        leds_in = 5'($urandom);
        lat      = 0;
        busy_cnt = 0;
        stable   = 1'b1;
        while (!done && lat < 40) begin
            if (busy) busy_cnt++;
            if (bcd_out !== pb || leds_out !== pl || ovf !== po) stable = 1'b0;
            if (lat == inj_at) begin
                load    = 1'b1;
                bin_in  = 20'd111111;
                leds_in = 5'h1F;
            end else begin
                load = 1'b0;
            end
            @(posedge clk); #1;
            lat++;
        end
        load = 1'b0;
    endtask

    task automatic count_dones(input int cycles, output int n);
        n = 0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk); #1;
            if (done) n++;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          lat;
        int          bc;
        int          nd;
        bit          st;
        int unsigned v;
        logic [4:0]  l;

        tbl[0] = '{20'd0,       5'b10101, 24'h000000, 5'b10101, 1'b0};
        tbl[1] = '{20'd123456,  5'b00001, 24'h123456, 5'b00001, 1'b0};
        tbl[2] = '{20'd999999,  5'b11111, 24'h999999, 5'b11111, 1'b0};
        tbl[3] = '{20'd1000000, 5'b01010, 24'hEEEEEE, 5'b01010, 1'b1};
        tbl[4] = '{20'd42,      5'b00110, 24'h000042, 5'b00110, 1'b0};
        tbl[5] = '{20'd1048575, 5'b10000, 24'hEEEEEE, 5'b10000, 1'b1};
        tbl[6] = '{20'd100000,  5'b00000, 24'h100000, 5'b00000, 1'b0};
        tbl[7] = '{20'd59595,   5'b11000, 24'h059595, 5'b11000, 1'b0};

        rst     = 1'b1;
        load    = 1'b0;
        bin_in  = '0;
        leds_in = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_bcd",  32'(bcd_out),  32'h0);
        check("reset_leds", 32'(leds_out), 32'h0);
        check("reset_busy", 32'(busy),     32'h0);
        check("reset_done", 32'(done),     32'h0);
        check("reset_ovf",  32'(ovf),      32'h0);
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 8; i++) begin
            do_conv(tbl[i].b, tbl[i].l, -1, lat, bc, st);
            check($sformatf("tbl%0d_bcd", i),    32'(bcd_out),  32'(tbl[i].eb));
            check($sformatf("tbl%0d_leds", i),   32'(leds_out), 32'(tbl[i].el));
            check($sformatf("tbl%0d_ovf", i),    32'(ovf),      32'(tbl[i].eo));
            check($sformatf("tbl%0d_lat", i),    32'(lat),      32'd21);
            check($sformatf("tbl%0d_busy", i),   32'(bc),       32'd21);
            check($sformatf("tbl%0d_stable", i), 32'(st),       32'd1);
            check($sformatf("tbl%0d_busy_lo", i), 32'(busy),    32'd0);
            @(posedge clk); #1;
            check($sformatf("tbl%0d_done_1cyc", i), 32'(done), 32'd0);
        end

        // Load while busy is dropped, not queued.
        do_conv(20'd654321, 5'h0A, 5, lat, bc, st);
        check("ign_bcd",  32'(bcd_out),  32'h654321);
        check("ign_leds", 32'(leds_out), 32'h0A);
        check("ign_lat",  32'(lat),      32'd21);
        count_dones(30, nd);
        check("ign_single_done", 32'(nd), 32'd0);

        // Back-to-back: second load in the done cycle.
        do_conv(20'd7, 5'h03, -1, lat, bc, st);
        check("b2b_first_bcd", 32'(bcd_out), 32'h000007);
        do_conv(20'd8, 5'h04, -1, lat, bc, st);
        check("b2b_second_bcd",  32'(bcd_out),  32'h000008);
        check("b2b_second_leds", 32'(leds_out), 32'h04);
        check("b2b_second_lat",  32'(lat),      32'd21);
        @(posedge clk); #1;

        // Reset in the middle of a conversion.
        do_conv(20'd555555, 5'h11, -1, lat, bc, st);
        check("pre_rst_bcd", 32'(bcd_out), 32'h555555);
        load    = 1'b1;
        bin_in  = 20'd777777;
        leds_in = 5'h1E;
        @(posedge clk); #1;
        load = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("midrst_bcd",  32'(bcd_out),  32'h0);
        check("midrst_leds", 32'(leds_out), 32'h0);
        check("midrst_busy", 32'(busy),     32'h0);
        check("midrst_done", 32'(done),     32'h0);
        check("midrst_ovf",  32'(ovf),      32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        count_dones(30, nd);
        check("midrst_no_done", 32'(nd), 32'd0);
        do_conv(20'd314159, 5'h05, -1, lat, bc, st);
        check("postrst_bcd", 32'(bcd_out), 32'h314159);
        check("postrst_lat", 32'(lat),     32'd21);
        @(posedge clk); #1;

        // Reset released with load already high.
        rst     = 1'b1;
        load    = 1'b1;
        bin_in  = 20'd271828;
        leds_in = 5'h15;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        do_conv(20'd271828, 5'h15, -1, lat, bc, st);
        check("rel_load_bcd",  32'(bcd_out),  32'h271828);
        check("rel_load_leds", 32'(leds_out), 32'h15);
        check("rel_load_lat",  32'(lat),      32'd21);
        @(posedge clk); #1;

        // Random values against the decimal reference.
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 3) == 0) v = $urandom_range(0, 1048575);
            else                           v = $urandom_range(0, 999999);
            l = 5'($urandom);
            do_conv(20'(v), l, -1, lat, bc, st);
            check($sformatf("rnd%0d_bcd(%0d)", i, v), 32'(bcd_out),  32'(ref_bcd(v)));
            check($sformatf("rnd%0d_leds", i),        32'(leds_out), 32'(l));
            check($sformatf("rnd%0d_ovf", i),         32'(ovf),      32'(v > 999999));
            check($sformatf("rnd%0d_lat", i),         32'(lat),      32'd21);
            if ($urandom_range(0, 1) == 1) begin
                @(posedge clk); #1;
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
